lsu_bridge: RTL

LSU_BRIDGE -- requirements
Module: lsu_bridge

---
 rtl/lsu_bridge_pkg.sv | 57 +++++
 rtl/lsu_bridge_load_align.sv | 37 +++
 rtl/lsu_bridge.sv | 121 ++++++++++++
 3 files changed

// File: rtl/lsu_bridge_pkg.sv
// Shared definitions for the load/store bridge: access-size codes, FSM
// encoding and the helpers that turn an M-stage access into bus fields.
package lsu_bridge_pkg;

   // Access size codes carried on lshbM; 101-111 behave as a word access.
   localparam logic [2:0] LSHB_W  = 3'b000;
   localparam logic [2:0] LSHB_HS = 3'b001;
   localparam logic [2:0] LSHB_HU = 3'b010;
   localparam logic [2:0] LSHB_BS = 3'b011;
   localparam logic [2:0] LSHB_BU = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [1:0]  off;
      logic [2:0]  lshb;
   } lsu_req_t;

   function automatic logic is_half(input logic [2:0] c);
      return (c == LSHB_HS) || (c == LSHB_HU);
   endfunction

   function automatic logic is_byte(input logic [2:0] c);
      return (c == LSHB_BS) || (c == LSHB_BU);
   endfunction

   function automatic logic misaligned(input logic [2:0] c, input logic [1:0] off);
      if (is_byte(c)) return 1'b0;
      if (is_half(c)) return off[0];
      return off != 2'b00;
   endfunction

   function automatic logic [3:0] strb_of(input logic wr, input logic [2:0] c,
                                          input logic [1:0] off);
      if (!wr) return 4'b0000;
      if (is_byte(c)) return 4'b0001 << off;
      if (is_half(c)) return 4'b0011 << off;
      return 4'b1111;
   endfunction

   // Store data is replicated across the word so the strobes pick the lane.
   function automatic logic [31:0] wdata_of(input logic [2:0] c, input logic [31:0] d);
      if (is_byte(c)) return {4{d[7:0]}};
      if (is_half(c)) return {2{d[15:0]}};
      return d;
   endfunction

endpackage

// File: rtl/lsu_bridge_load_align.sv
// Load extraction: pick the addressed byte/half from a bus word and
// sign- or zero-extend it according to the access size code.
module load_align
   import lsu_bridge_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_off,
   input  logic [2:0]  i_lshb,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_data = i_rdata;
      case (i_lshb)
         LSHB_HS: o_data = {{16{w_half[15]}}, w_half};
         LSHB_HU: o_data = {16'h0000, w_half};
         LSHB_BS: o_data = {{24{w_byte[7]}}, w_byte};
         LSHB_BU: o_data = {24'h000000, w_byte};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_bridge.sv
// M-stage load/store to addr_ok/data_ok bus bridge; stalls the pipeline
// while an access is in flight and returns the aligned load result.
module lsu_bridge
   import lsu_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        memreqM,
   input  logic        memwriteM,
   input  logic [2:0]  lshbM,
   input  logic [31:0] addrM,
   input  logic [31:0] wdataM,
   input  logic        stall_ext,
   output logic        stallM,
   output logic [31:0] ldataM,
   output logic        adelM,
   output logic        adesM,
   output logic        data_req,
   output logic        data_wr,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   lsu_state_e  r_state, w_next;
   lsu_req_t    w_req, r_req;
   logic [31:0] r_hold;
   logic        w_mis, w_go, w_idle;
   logic        w_breq, w_stall, w_ld_live, w_ld_hold;
   logic [31:0] w_align_src, w_align_out;

   assign w_mis  = misaligned(lshbM, addrM[1:0]);
   assign w_go   = memreqM & ~w_mis;
   assign w_idle = (r_state == ST_IDLE);

   always_comb begin
      w_req       = '0;
      w_req.wr    = memwriteM;
      w_req.addr  = {addrM[31:2], 2'b00};
      w_req.wstrb = strb_of(memwriteM, lshbM, addrM[1:0]);
      w_req.wdata = wdata_of(lshbM, wdataM);
      w_req.off   = addrM[1:0];
      w_req.lshb  = lshbM;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_breq    = 1'b0;
      w_stall   = 1'b0;
      w_ld_live = 1'b0;
      w_ld_hold = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_go) begin
               w_breq  = 1'b1;
               w_stall = 1'b1;
               w_next  = data_addr_ok ? ST_DATA : ST_ADDR;
            end
         end
         ST_ADDR: begin
            w_breq  = 1'b1;
            w_stall = 1'b1;
            if (data_addr_ok) w_next = ST_DATA;
         end
         ST_DATA: begin
            if (data_data_ok) begin
               w_ld_live = 1'b1;
               w_next    = stall_ext ? ST_DONE : ST_IDLE;
            end else begin
               w_stall = 1'b1;
            end
         end
         ST_DONE: begin
            w_ld_hold = 1'b1;
            if (!stall_ext) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Request fields are latched at issue so ADDR/DATA/DONE never depend on
   // whatever the M stage presents later.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req  <= '0;
         r_hold <= '0;
      end else begin
         if (w_idle && w_go)                  r_req  <= w_req;
         if (r_state == ST_DATA && data_data_ok) r_hold <= data_rdata;
      end
   end

   assign w_align_src = w_ld_hold ? r_hold : data_rdata;

   load_align u_align (
      .i_rdata (w_align_src),
      .i_off   (r_req.off),
      .i_lshb  (r_req.lshb),
      .o_data  (w_align_out)
   );

   assign data_req   = w_breq & ~rst;
   assign data_wr    = w_idle ? w_req.wr    : r_req.wr;
   assign data_addr  = w_idle ? w_req.addr  : r_req.addr;
   assign data_wstrb = w_idle ? w_req.wstrb : r_req.wstrb;
   assign data_wdata = w_idle ? w_req.wdata : r_req.wdata;

   assign stallM = w_stall & ~rst;
   assign adelM  = ~rst & memreqM & ~memwriteM & w_mis;
   assign adesM  = ~rst & memreqM &  memwriteM & w_mis;
   assign ldataM = (~rst & ~r_req.wr & (w_ld_live | w_ld_hold)) ? w_align_out : 32'h0;

endmodule
